// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port word SRAM slave with programmable wait states and
// a two-cycle ERROR response for out-of-window or misaligned accesses.
module ahb_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE = {1'b0, ADDR_BASE};
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [IW-1:0] idx_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [32:0]   off;
  logic [IW-1:0] idx_new;
  logic          addr_ok, open, take;
  logic          rd_direct, rd_late, fwd;

  // 33-bit arithmetic keeps the upper window bound exact even at the top of the map.
  assign off     = {1'b0, HADDR} - BASE;
  assign addr_ok = ({1'b0, HADDR} >= BASE) && (off < SPAN) && (HADDR[1:0] == 2'b00);
  assign idx_new = off[IW+1:2];

  assign open = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
  assign take = open && HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      idx_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        idx_q <= idx_new;
        wr_q  <= HWRITE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 4'd0) state_nxt = S_LAST;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2:  HRESP = 1'b1;
      default: ;
    endcase
    // IDLE, LAST and ERR2 all accept the next address phase the same way.
    if (open) begin
      if (!take)          state_nxt = S_IDLE;
      else if (!addr_ok)  state_nxt = S_ERR1;
      else if (WS != 4'd0) begin
        state_nxt = S_WAIT;
        cnt_nxt   = WS - 4'd1;
      end else            state_nxt = S_LAST;
    end
  end

  assign rd_direct = take && addr_ok && !HWRITE && (WS == 4'd0);
  assign rd_late   = (state == S_WAIT) && (cnt == 4'd0) && !wr_q;
  // A write finishing in this LAST cycle is not yet in mem; bypass it to the read.
  assign fwd       = (state == S_LAST) && wr_q && (idx_q == idx_new);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         HRDATA <= 32'd0;
    else if (rd_direct) HRDATA <= fwd ? HWDATA : mem[idx_new];
    else if (rd_late)   HRDATA <= mem[idx_q];
  end

  always_ff @(posedge clk) begin
    if ((state == S_LAST) && wr_q) mem[idx_q] <= HWDATA;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: pipelined AHB master driving two instances
// (0 and 3 wait states) against a word-array memory model.
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h1000_0400;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel0, sel3, use3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hready;
  logic        ro0, ro3, resp0, resp3;
  logic [31:0] rd0, rd3;

  always #5 clk = ~clk;
  assign hready = use3 ? ro3 : ro0;

  ahb_sram_slave #(.ADDR_BASE(BASE0), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0));

  ahb_sram_slave #(.ADDR_BASE(BASE3), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rd3));

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic        idle;
  } txn_t;

  txn_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model [2][DEPTH];
  bit          known [2][DEPTH];

  function automatic logic [31:0] base_of(input int inst);
    return (inst != 0) ? BASE3 : BASE0;
  endfunction

  function automatic bit is_err(input int inst, input logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, base_of(inst)};
    hi = lo + 33'(4 * DEPTH);
    return ({1'b0, a} < lo) || ({1'b0, a} >= hi) || (a[1:0] != 2'b00);
  endfunction

  function automatic int idx_of(input int inst, input logic [31:0] a);
    return int'((a - base_of(inst)) >> 2);
  endfunction

  task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
    q.push_back('{addr: a, wr: w, data: d, idle: 1'b0});
  endtask

  task automatic push_idle();
    q.push_back('{addr: 32'd0, wr: 1'b0, data: 32'd0, idle: 1'b1});
  endtask

  // Drains q through one instance as a pipelined AHB master and checks every data phase.
  task automatic run(input int inst, input string name);
    txn_t        dp, t;
    logic        dpv, rdy, resp, exp_err, cur_sel;
    logic [31:0] rd;
    int          waits, cyc, ws, ix;
    dpv = 1'b0; waits = 0; cyc = 0; ws = (inst != 0) ? 3 : 0;
    use3 = (inst != 0);
    if (inst != 0) sel0 = 1'b0; else sel3 = 1'b0;
    do begin
      @(posedge clk); #1; cyc++;
      rdy  = (inst != 0) ? ro3 : ro0;
      resp = (inst != 0) ? resp3 : resp0;
      rd   = (inst != 0) ? rd3 : rd0;
      hwdata = dpv ? dp.data : $urandom();
      if (dpv) begin
        exp_err = is_err(inst, dp.addr);
        n_chk++;
        if (resp !== exp_err) begin
          n_fail++;
          $display("FAIL %s hresp addr=%h: got %b want %b", name, dp.addr, resp, exp_err);
        end
        if (rdy === 1'b0) waits++;
        else begin
          n_chk++;
          if (waits != (exp_err ? 1 : ws)) begin
            n_fail++;
            $display("FAIL %s wait_cycles addr=%h: got %0d want %0d", name, dp.addr, waits,
                     exp_err ? 1 : ws);
          end
          if (!exp_err) begin
            ix = idx_of(inst, dp.addr);
            if (dp.wr) begin
              model[inst][ix] = dp.data;
              known[inst][ix] = 1'b1;
            end else if (known[inst][ix]) begin
              n_chk++;
              if (rd !== model[inst][ix]) begin
                n_fail++;
                $display("FAIL %s hrdata addr=%h: got %h want %h", name, dp.addr, rd,
                         model[inst][ix]);
              end
            end
          end
          dpv = 1'b0; waits = 0;
        end
      end else begin
        n_chk++;
        if (rdy !== 1'b1 || resp !== 1'b0) begin
          n_fail++;
          $display("FAIL %s idle_resp: got ready=%b resp=%b want 1/0", name, rdy, resp);
        end
      end
      cur_sel = 1'b1; htrans = 2'b00;
      if (rdy === 1'b1 && q.size() > 0) begin
        t = q.pop_front();
        if (t.idle) begin
          case ($urandom_range(0, 2))
            0:       begin cur_sel = 1'b0; htrans = 2'b10; haddr = base_of(inst) + 32'd16; end
            1:       htrans = 2'b00;
            default: htrans = 2'b01;
          endcase
          hwrite = $urandom_range(0, 1) != 0;
        end else begin
          htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
          haddr  = t.addr;
          hwrite = t.wr;
          dp     = t;
          dpv    = 1'b1;
        end
      end
      if (inst != 0) sel3 = cur_sel; else sel0 = cur_sel;
    end while ((q.size() > 0 || dpv) && cyc < 5000);
    if (q.size() > 0 || dpv) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: got %0d cycles want completion", name, cyc);
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel0 = 1'b1; sel3 = 1'b1; use3 = 1'b0;
    htrans = 2'b10; hwrite = 1'b0; haddr = BASE3; hwdata = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({ro0, resp0, rd0} !== {1'b1, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_ws0: got ready=%b resp=%b rdata=%h want 1/0/0", ro0, resp0, rd0);
      end
      n_chk++;
      if ({ro3, resp3, rd3} !== {1'b1, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_ws3: got ready=%b resp=%b rdata=%h want 1/0/0", ro3, resp3, rd3);
      end
    end
    htrans = 2'b00;
    rst_n  = 1'b1;
  endtask

  task automatic test_write_read();
    push(BASE0 + 32'd8, 1'b1, 32'hDEAD_BEEF);
    push_idle();
    push(BASE0 + 32'd8, 1'b0, 32'd0);
    run(0, "write_read_ws0");
  endtask

  task automatic test_back_to_back();
    push(BASE0 + 32'd4, 1'b1, 32'h1234_5678);
    push(BASE0 + 32'd4, 1'b0, 32'd0);
    push(BASE0 + 32'd4, 1'b1, 32'h0BAD_F00D);
    push(BASE0 + 32'd8, 1'b0, 32'd0);
    push(BASE0 + 32'd4, 1'b0, 32'd0);
    run(0, "back_to_back_ws0");
    push(BASE3 + 32'd4, 1'b1, 32'h1234_5678);
    push(BASE3 + 32'd4, 1'b0, 32'd0);
    run(1, "back_to_back_ws3");
  endtask

  task automatic test_wait_states();
    push(BASE3 + 32'd8, 1'b1, 32'hCAFE_0003);
    push(BASE3 + 32'd12, 1'b1, 32'h5555_AAAA);
    push(BASE3 + 32'd8, 1'b0, 32'd0);
    push_idle();
    push(BASE3 + 32'd12, 1'b0, 32'd0);
    run(1, "wait_states_ws3");
  endtask

  task automatic test_error();
    for (int inst = 0; inst < 2; inst++) begin
      push(base_of(inst), 1'b1, 32'hA0A0_0000);
      push(base_of(inst) + 32'd4, 1'b1, 32'hA0A0_0004);
      push(base_of(inst) + 32'd1020, 1'b1, 32'hA0A0_03FC);
      push(base_of(inst) + 32'd1024, 1'b1, 32'hEEEE_0001);
      push(base_of(inst) + 32'd2, 1'b1, 32'hEEEE_0002);
      push(base_of(inst) + 32'd1024, 1'b0, 32'd0);
      push(base_of(inst) - 32'd4, 1'b1, 32'hEEEE_0003);
      push(base_of(inst) + 32'd1020, 1'b0, 32'd0);
      push(base_of(inst), 1'b0, 32'd0);
      push(base_of(inst) + 32'd4, 1'b0, 32'd0);
      run(inst, (inst != 0) ? "error_ws3" : "error_ws0");
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          r;
    for (int inst = 0; inst < 2; inst++) begin
      for (int n = 0; n < 200; n++) begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          a = base_of(inst) + 32'(4 * ($urandom_range(0, 1) != 0 ? $urandom_range(0, 3)
                                                                : $urandom_range(252, 255)));
          push(a, $urandom_range(0, 1) != 0, $urandom());
        end else if (r == 7) begin
          push(base_of(inst) + 32'(4 * DEPTH + 4 * $urandom_range(0, 3)),
               $urandom_range(0, 1) != 0, $urandom());
        end else if (r == 8) begin
          push(base_of(inst) + 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3)),
               $urandom_range(0, 1) != 0, $urandom());
        end else push_idle();
      end
      run(inst, (inst != 0) ? "random_ws3" : "random_ws0");
    end
  endtask

  task automatic test_reset_abort();
    push(BASE3, 1'b1, 32'h0123_4567);
    run(1, "abort_setup");
    @(posedge clk); #1;
    sel3 = 1'b1; haddr = BASE3; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hFFFF_0000;
    n_chk++;
    if (ro3 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_wait: got ready=%b want 0", ro3);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ro3, resp3, rd3} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL abort_async_reset: got ready=%b resp=%b rdata=%h want 1/0/0",
               ro3, resp3, rd3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(BASE3, 1'b0, 32'd0);
    run(1, "abort_readback");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
